// File: rtl/mist_core_pkg.sv
// Shared definitions for the core reset controller: FSM state encoding and default stretch length.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mist_core_pkg;

  // Reset-controller FSM states (2-bit encoding)
  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,  // waiting for all required images
    S_DL      = 2'd1,  // loader owns the bus, image in flight
    S_STRETCH = 2'd2,  // images ready, holding reset for the stretch window
    S_RUN     = 2'd3   // core released
  } rst_state_t;

  // Default number of cycles core_reset is held after a release condition
  localparam int unsigned STRETCH_DEF = 16;

endpackage

// File: rtl/core_reset_ctrl.sv
// Core reset sequencer: tracks ioctl image downloads and releases core_reset once required images are loaded.
// Latency: core_reset is registered; it drops STRETCH cycles after the cycle that enters the stretch window.
// Backpressure: none; all inputs are level signals sampled every clk_sys cycle, nothing is ever stalled.
module core_reset_ctrl
  import mist_core_pkg::*;
#(
  parameter int unsigned        NUM_IDX  = 4,
  parameter logic [NUM_IDX-1:0] REQ_MASK = NUM_IDX'(1),
  parameter int unsigned        STRETCH  = STRETCH_DEF
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_downl,
  input  logic [7:0]         ioctl_index,
  input  logic               soft_rst,
  output logic               core_reset,
  output logic [NUM_IDX-1:0] loaded,
  output logic               rom_ready,
  output logic               dl_active,
  output logic               dl_index_err
);

  localparam int unsigned      CNT_W    = $clog2(STRETCH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);

  rst_state_t         state;
  rst_state_t         next_state;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_load;
  logic               cnt_dec;
  logic               core_reset_nxt;

  logic               dl_armed;   // ioctl_downl seen low outside an aborted download
  logic [7:0]         cur_idx;
  logic               rise;
  logic               fall;
  logic               cur_ok;
  logic [NUM_IDX-1:0] loaded_nxt;
  logic               rom_ready_nxt;

  // A download only counts when its start was observed; one that was live across reset is ignored.
  assign rise   = ioctl_downl & ~dl_active & dl_armed;
  assign fall   = ~ioctl_downl & dl_active & dl_armed;
  assign cur_ok = (cur_idx < 8'(NUM_IDX));

  // Per-index loaded flags after this cycle: a starting image is invalidated, a finished one is marked.
  always_comb begin
    loaded_nxt = loaded;
    for (int i = 0; i < NUM_IDX; i++) begin
      if (rise && (ioctl_index == 8'(i))) loaded_nxt[i] = 1'b0;
      if (fall && (cur_idx == 8'(i)))     loaded_nxt[i] = 1'b1;
    end
  end

  assign rom_ready     = &(loaded | ~REQ_MASK);
  assign rom_ready_nxt = &(loaded_nxt | ~REQ_MASK);

  // Download tracking: edge-detect register, current index, loaded flags and bad-index pulse.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_active    <= 1'b0;
      dl_armed     <= ~ioctl_downl;
      cur_idx      <= '0;
      loaded       <= '0;
      dl_index_err <= 1'b0;
    end else begin
      dl_active    <= ioctl_downl;
      if (!ioctl_downl) dl_armed <= 1'b1;
      if (rise) cur_idx <= ioctl_index;
      loaded       <= loaded_nxt;
      dl_index_err <= fall & ~cur_ok;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= S_WAIT;
    else       state <= next_state;
  end

  // Next-state logic: a new download start overrides everything else.
  always_comb begin
    next_state = state;
    if (rise) begin
      next_state = S_DL;
    end else begin
      case (state)
        S_WAIT:    if (rom_ready && !ioctl_downl) next_state = S_STRETCH;
        S_DL:      if (fall) next_state = rom_ready_nxt ? S_STRETCH : S_WAIT;
        S_STRETCH: if ((cnt == '0) && !soft_rst) next_state = S_RUN;
        S_RUN:     if (soft_rst) next_state = S_STRETCH;
        default:   next_state = S_WAIT;
      endcase
    end
  end

  // FSM outputs: registered reset request and stretch-counter controls.
  always_comb begin
    core_reset_nxt = (next_state != S_RUN);
    cnt_load       = (next_state == S_STRETCH) && ((state != S_STRETCH) || soft_rst);
    cnt_dec        = (state == S_STRETCH) && (next_state == S_STRETCH) && (cnt != '0);
  end

  // Stretch counter and core_reset register; a held soft_rst keeps restarting the window.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cnt        <= '0;
      core_reset <= 1'b1;
    end else begin
      core_reset <= core_reset_nxt;
      if (cnt_load)     cnt <= CNT_LOAD;
      else if (cnt_dec) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: doc/core_reset_ctrl.md
CORE_RESET_CTRL -- requirements
Module: core_reset_ctrl

Interface
REQ-001 SHALL have parameter NUM_IDX, default 4: number of tracked ioctl download indexes (1..8).
REQ-002 SHALL have parameter REQ_MASK [NUM_IDX-1:0], default 'b0001: indexes that must be loaded before the core may run.
REQ-003 SHALL have parameter STRETCH, default 16: number of cycles core_reset is held after any release condition (minimum 1).
REQ-004 SHALL have port clk_sys, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high block reset (e.g. ~pll_locked).
REQ-006 SHALL have port ioctl_downl, input, 1 bit: download in progress, synchronous to clk_sys.
REQ-007 SHALL have port ioctl_index, input, 8 bits: index of the current download.
REQ-008 SHALL have port soft_rst, input, 1 bit: user reset request (OSD reset or button), level-sensitive.
REQ-009 SHALL have port core_reset, output, 1 bit: registered, active-high reset to the game core.
REQ-010 SHALL have port loaded, output, NUM_IDX bits: per-index image-complete flags.
REQ-011 SHALL have port rom_ready, output, 1 bit: all REQ_MASK indexes are loaded.
REQ-012 SHALL have port dl_active, output, 1 bit: registered copy of ioctl_downl.
REQ-013 SHALL have port dl_index_err, output, 1 bit: one-cycle pulse when a download of index >= NUM_IDX completes.

Function
REQ-014 SHALL register ioctl_downl as dl_active; rise = ioctl_downl & ~dl_active; fall = ~ioctl_downl & dl_active.
REQ-015 SHALL latch ioctl_index into cur_idx on rise.
REQ-016 SHALL clear loaded[ioctl_index] on rise when ioctl_index < NUM_IDX, so partial images never count as loaded.
REQ-017 SHALL set loaded[cur_idx] on fall when cur_idx < NUM_IDX; otherwise SHALL pulse dl_index_err for exactly that cycle and leave loaded unchanged.
REQ-018 SHALL compute rom_ready combinationally as &(loaded | ~REQ_MASK).
REQ-019 SHALL implement an FSM with states S_WAIT, S_DL, S_STRETCH and S_RUN.
REQ-020 SHALL transition from any state to S_DL on rise; this has priority over every other transition.
REQ-021 SHALL transition from S_DL on fall to S_STRETCH if rom_ready holds after the fall's loaded update, else to S_WAIT.
REQ-022 SHALL transition from S_WAIT to S_STRETCH when rom_ready=1 and ioctl_downl=0.
REQ-023 SHALL load a down-counter of width $clog2(STRETCH+1) with STRETCH-1 on entry to S_STRETCH.
REQ-024 SHALL, in S_STRETCH, decrement the counter each cycle, reload STRETCH-1 while soft_rst=1, and transition to S_RUN when the counter is 0 and soft_rst=0.
REQ-025 SHALL transition from S_RUN to S_STRETCH when soft_rst=1.
REQ-026 SHALL register core_reset = (next_state != S_RUN), so core_reset is high for exactly STRETCH cycles after the S_STRETCH entry edge when soft_rst=0.
REQ-027 SHALL, when rise and soft_rst coincide, resolve to S_DL (REQ-020).
REQ-028 SHALL, when a download of a non-REQ_MASK index occurs while in S_RUN, still hold core_reset high through S_DL and S_STRETCH, because the core bus shares SDRAM with the loader.

Reset
REQ-029 SHALL, while reset=1, drive state S_WAIT, core_reset=1, loaded=0, dl_active=0, dl_index_err=0, counter=0 and cur_idx=0; rom_ready then follows REQ-018.
REQ-030 SHALL, on reset asserted mid-download, discard the download; a fall arriving after reset release without a prior rise SHALL NOT set any loaded bit.

Structure
REQ-031 SHALL place the FSM state enum (2 bits) and the default STRETCH value in shared package mist_core_pkg.
REQ-032 SHALL be a single module with no sub-modules; the edge detect and counter are inline.

Verification
REQ-033 SHALL cover: reset, then download index 0 for 10 cycles -> loaded=4'b0001, rom_ready=1, core_reset falls exactly 16 cycles after the fall edge plus the 1-cycle register.
REQ-034 SHALL cover: with REQ_MASK='b0011, download index 1 only -> FSM stays in S_WAIT with core_reset=1; then download index 0 -> run after 16 cycles.
REQ-035 SHALL cover: in S_RUN, soft_rst held high 5 cycles -> core_reset high for 5+16 cycles total, then low.
REQ-036 SHALL cover: download of index 7 with NUM_IDX=4 -> single-cycle dl_index_err, loaded unchanged, core_reset released 16 cycles later if already rom_ready.
REQ-037 SHALL cover: re-download of index 0 from S_RUN -> loaded[0]=0 and core_reset=1 on the cycle after the rise; loaded[0] returns to 1 on completion.
REQ-038 SHALL cover: reset asserted mid-download, then a lone fall -> loaded stays 0 and core_reset stays 1.
